// File: rtl/fnd_scan_display.sv
// Binary-to-7-segment display driver: sequential double-dabble conversion into a
// committed BCD register, plus a refresh-tick scan over four multiplexed digits.
module fnd_scan_display #(
    parameter int REFRESH_DIV = 100_000,
    parameter int VALUE_W     = 14,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [VALUE_W-1:0] i_value,
    output logic               o_busy,
    output logic               o_ovf,
    output logic [1:0]         o_digitSelect,
    output logic [3:0]         o_digit,
    output logic [7:0]         o_font
);

    localparam int                 DIV_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [VALUE_W-1:0] MAX_VALUE = VALUE_W'(9999);
    localparam logic [3:0]         LAST_BIT  = 4'(VALUE_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit.
    function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic in_bit);
        logic [15:0] adj;
        adj = bcd;
        for (int k = 0; k < 4; k++) begin
            if (bcd[k*4 +: 4] >= 4'd5) begin
                adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
            end else begin
                adj[k*4 +: 4] = bcd[k*4 +: 4];
            end
        end
        return {adj[14:0], in_bit};
    endfunction

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    conv_state_t        state_r;
    conv_state_t        state_s;
    logic               capture_s;
    logic               commit_s;
    logic [VALUE_W-1:0] bin_r;
    logic [15:0]        work_r;
    logic [15:0]        step_s;
    logic [3:0]         bit_cnt_r;
    logic [15:0]        disp_bcd_r;
    logic               busy_r;
    logic               ovf_r;

    logic [DIV_W-1:0]   div_r;
    logic [1:0]         idx_r;
    logic [1:0]         idx_s;
    logic               wrap_s;
    logic [3:0]         digit_val_s;
    logic [3:0]         lz_s;
    logic [7:0]         font_s;
    logic [1:0]         sel_r;
    logic [3:0]         digit_r;
    logic [7:0]         font_r;

    // Converter state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Converter next-state and capture/commit strobes.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_load) begin
                    state_s   = ST_CONV;
                    capture_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (bit_cnt_r == LAST_BIT) begin
                    state_s  = ST_IDLE;
                    commit_s = 1'b1;
                end else begin
                    state_s = ST_CONV;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next double-dabble result from the working register.
    always_comb begin
        step_s = dd_step(work_r, bin_r[VALUE_W-1]);
    end

    // Conversion datapath; the display register only changes on the final step.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bin_r      <= '0;
            work_r     <= 16'h0000;
            bit_cnt_r  <= 4'd0;
            disp_bcd_r <= 16'h0000;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (capture_s) begin
            bin_r     <= (i_value > MAX_VALUE) ? MAX_VALUE : i_value;
            ovf_r     <= (i_value > MAX_VALUE);
            work_r    <= 16'h0000;
            bit_cnt_r <= 4'd0;
            busy_r    <= 1'b1;
        end else if (state_r == ST_CONV) begin
            work_r    <= step_s;
            bin_r     <= {bin_r[VALUE_W-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (commit_s) begin
                disp_bcd_r <= step_s;
                busy_r     <= 1'b0;
            end
        end
    end

    // Refresh divider and scan index.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_r <= '0;
            idx_r <= 2'd0;
        end else begin
            div_r <= wrap_s ? '0 : div_r + DIV_W'(1);
            idx_r <= idx_s;
        end
    end

    // Outputs are built from the upcoming index so select, anode and font move together.
    always_comb begin
        wrap_s = (div_r == DIV_LAST);
        if (wrap_s) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end
        digit_val_s = disp_bcd_r[{idx_s, 2'b00} +: 4];
        lz_s[3] = (disp_bcd_r[15:12] == 4'd0);
        lz_s[2] = lz_s[3] && (disp_bcd_r[11:8] == 4'd0);
        lz_s[1] = lz_s[2] && (disp_bcd_r[7:4] == 4'd0);
        lz_s[0] = 1'b0;
        if (BLANK_LZ && lz_s[idx_s]) begin
            font_s = 8'hFF;
        end else begin
            font_s = seg_font(digit_val_s);
        end
    end

    // Registered display outputs; disabling only blanks them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sel_r   <= 2'd0;
            digit_r <= 4'b1111;
            font_r  <= 8'hFF;
        end else begin
            sel_r <= idx_s;
            if (i_en) begin
                digit_r <= ~(4'b0001 << idx_s);
                font_r  <= font_s;
            end else begin
                digit_r <= 4'b1111;
                font_r  <= 8'hFF;
            end
        end
    end

    assign o_busy        = busy_r;
    assign o_ovf         = ovf_r;
    assign o_digitSelect = sel_r;
    assign o_digit       = digit_r;
    assign o_font        = font_r;

endmodule

// File: tb/tb_fnd_scan_display.sv
// Self-checking bench for fnd_scan_display: decimal reference model of the shown value
// and a cycle-count model of the scan position.
module tb_fnd_scan_display;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [13:0] value;
    logic        busy, ovf, busy_nb, ovf_nb;
    logic [1:0]  sel, sel_nb;
    logic [3:0]  digit, digit_nb;
    logic [7:0]  font, font_nb;

    int n_chk  = 0;
    int n_fail = 0;
    int edges;
    logic en_q;
    int model_val;
    bit model_ovf;

    logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_scan_display #(.REFRESH_DIV(4), .VALUE_W(14), .BLANK_LZ(1'b1)) dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_load(load), .i_value(value),
        .o_busy(busy), .o_ovf(ovf), .o_digitSelect(sel), .o_digit(digit), .o_font(font)
    );

    fnd_scan_display #(.REFRESH_DIV(4), .VALUE_W(14), .BLANK_LZ(1'b0)) dut_nb (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_load(load), .i_value(value),
        .o_busy(busy_nb), .o_ovf(ovf_nb), .o_digitSelect(sel_nb), .o_digit(digit_nb),
        .o_font(font_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; the scan position is edges/4 mod 4.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    always @(posedge clk) en_q <= en;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] exp_font(input int val, input int idx, input bit blank);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (blank && idx > 0 && val < p) return 8'hFF;
        return font_tab[(val / p) % 10];
    endfunction

    function automatic logic [3:0] exp_digit(input int idx, input logic on);
        logic [3:0] d;
        d = 4'b0001 << idx;
        return on ? ~d : 4'b1111;
    endfunction

    // Stimulus only: load v from idle and wait until the new value is on the display.
    task automatic do_load(input int v, output int busy_n);
        load = 1'b1;
        value = 14'(v);
        @(negedge clk);
        load = 1'b0;
        busy_n = 0;
        while (busy === 1'b1 && busy_n < 40) begin
            busy_n++;
            @(negedge clk);
        end
        @(negedge clk);
        model_val = (v > 9999) ? 9999 : v;
        model_ovf = (v > 9999);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; load = 1'b0; value = 14'd0;
        model_val = 0; model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_chk++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        n_chk++; if (digit !== 4'b1111) begin n_fail++; $display("FAIL reset_digit: got %b expected 1111", digit); end
        n_chk++; if (font !== 8'hFF) begin n_fail++; $display("FAIL reset_font: got %h expected ff", font); end
        en = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_idle_scan;
        int es;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            es = (edges / 4) % 4;
            n_chk++; if (sel !== es[1:0]) begin n_fail++; $display("FAIL idle_sel c%0d: got %0d expected %0d", c, sel, es); end
            n_chk++; if (digit !== exp_digit(es, en_q)) begin n_fail++; $display("FAIL idle_digit c%0d: got %b expected %b", c, digit, exp_digit(es, en_q)); end
            n_chk++; if (font !== exp_font(0, es, 1'b1)) begin n_fail++; $display("FAIL idle_font c%0d: got %h expected %h", c, font, exp_font(0, es, 1'b1)); end
            n_chk++; if (font_nb !== 8'hC0) begin n_fail++; $display("FAIL idle_font_nb c%0d: got %h expected c0", c, font_nb); end
        end
    endtask

    task automatic test_load_basic;
        int bn, es;
        load = 1'b1; value = 14'd1234;
        @(negedge clk);
        load = 1'b0;
        bn = 0;
        while (busy === 1'b1 && bn < 40) begin
            es = (edges / 4) % 4;
            n_chk++; if (font !== exp_font(model_val, es, 1'b1)) begin n_fail++; $display("FAIL load_old_font b%0d: got %h expected %h", bn, font, exp_font(model_val, es, 1'b1)); end
            bn++;
            @(negedge clk);
        end
        n_chk++; if (bn !== 14) begin n_fail++; $display("FAIL load_busy_len: got %0d expected 14", bn); end
        @(negedge clk);
        model_val = 1234; model_ovf = 1'b0;
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL load_ovf: got %b expected 0", ovf); end
        for (int c = 0; c < 16; c++) begin
            es = (edges / 4) % 4;
            n_chk++; if (sel !== es[1:0]) begin n_fail++; $display("FAIL load_sel c%0d: got %0d expected %0d", c, sel, es); end
            n_chk++; if (font !== exp_font(1234, es, 1'b1)) begin n_fail++; $display("FAIL load_font c%0d: got %h expected %h", c, font, exp_font(1234, es, 1'b1)); end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow;
        int bn, es;
        do_load(12000, bn);
        n_chk++; if (bn !== 14) begin n_fail++; $display("FAIL ovf_busy_len: got %0d expected 14", bn); end
        n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        for (int c = 0; c < 16; c++) begin
            n_chk++; if (font !== 8'h90) begin n_fail++; $display("FAIL ovf_font c%0d: got %h expected 90", c, font); end
            @(negedge clk);
        end
        do_load(7, bn);
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        for (int c = 0; c < 16; c++) begin
            es = (edges / 4) % 4;
            n_chk++; if (font !== exp_font(7, es, 1'b1)) begin n_fail++; $display("FAIL ovf_seven c%0d: got %h expected %h", c, font, exp_font(7, es, 1'b1)); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_load;
        int bn, es;
        load = 1'b1; value = 14'd42;
        @(negedge clk);
        load = 1'b0;
        bn = 0;
        while (busy === 1'b1 && bn < 40) begin
            bn++;
            load = (bn == 5);
            value = (bn == 5) ? 14'd5 : 14'd42;
            @(negedge clk);
        end
        load = 1'b0;
        n_chk++; if (bn !== 14) begin n_fail++; $display("FAIL ign_busy_len: got %0d expected 14", bn); end
        @(negedge clk);
        model_val = 42; model_ovf = 1'b0;
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ign_ovf: got %b expected 0", ovf); end
        for (int c = 0; c < 16; c++) begin
            es = (edges / 4) % 4;
            n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy c%0d: got %b expected 0", c, busy); end
            n_chk++; if (font !== exp_font(42, es, 1'b1)) begin n_fail++; $display("FAIL ign_font c%0d: got %h expected %h", c, font, exp_font(42, es, 1'b1)); end
            n_chk++; if (font_nb !== exp_font(42, es, 1'b0)) begin n_fail++; $display("FAIL ign_font_nb c%0d: got %h expected %h", c, font_nb, exp_font(42, es, 1'b0)); end
            @(negedge clk);
        end
    endtask

    task automatic test_enable;
        int es;
        en = 1'b0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c == 9) en = 1'b1;
            es = (edges / 4) % 4;
            n_chk++; if (sel !== es[1:0]) begin n_fail++; $display("FAIL en_sel c%0d: got %0d expected %0d", c, sel, es); end
            n_chk++; if (digit !== exp_digit(es, en_q)) begin n_fail++; $display("FAIL en_digit c%0d: got %b expected %b", c, digit, exp_digit(es, en_q)); end
            n_chk++; if (font !== (en_q ? exp_font(model_val, es, 1'b1) : 8'hFF)) begin n_fail++; $display("FAIL en_font c%0d: got %h expected %h", c, font, en_q ? exp_font(model_val, es, 1'b1) : 8'hFF); end
        end
    endtask

    task automatic test_random;
        int v, bn, es;
        for (int t = 0; t < 8; t++) begin
            v = int'($urandom_range(0, 16383));
            do_load(v, bn);
            n_chk++; if (bn !== 14) begin n_fail++; $display("FAIL rnd_busy_len v=%0d: got %0d expected 14", v, bn); end
            n_chk++; if (ovf !== model_ovf) begin n_fail++; $display("FAIL rnd_ovf v=%0d: got %b expected %b", v, ovf, model_ovf); end
            for (int c = 0; c < 16; c++) begin
                es = (edges / 4) % 4;
                n_chk++; if (digit !== exp_digit(es, en_q)) begin n_fail++; $display("FAIL rnd_digit v=%0d: got %b expected %b", v, digit, exp_digit(es, en_q)); end
                n_chk++; if (font !== (en_q ? exp_font(model_val, es, 1'b1) : 8'hFF)) begin n_fail++; $display("FAIL rnd_font v=%0d: got %h expected %h", v, font, en_q ? exp_font(model_val, es, 1'b1) : 8'hFF); end
                n_chk++; if (font_nb !== (en_q ? exp_font(model_val, es, 1'b0) : 8'hFF)) begin n_fail++; $display("FAIL rnd_font_nb v=%0d: got %h expected %h", v, font_nb, en_q ? exp_font(model_val, es, 1'b0) : 8'hFF); end
                en = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            en = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int vals [3] = '{9999, 10000, 305};
        int bn, es;
        for (int t = 0; t < 3; t++) begin
            do_load(vals[t], bn);
            n_chk++; if (bn !== 14) begin n_fail++; $display("FAIL b2b_busy_len v=%0d: got %0d expected 14", vals[t], bn); end
            n_chk++; if (ovf !== model_ovf) begin n_fail++; $display("FAIL b2b_ovf v=%0d: got %b expected %b", vals[t], ovf, model_ovf); end
        end
        for (int c = 0; c < 8; c++) begin
            es = (edges / 4) % 4;
            n_chk++; if (font !== exp_font(305, es, 1'b1)) begin n_fail++; $display("FAIL b2b_font c%0d: got %h expected %h", c, font, exp_font(305, es, 1'b1)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_conv;
        int bn, es;
        load = 1'b1; value = 14'd12000;
        @(negedge clk);
        load = 1'b0;
        bn = 0;
        while (bn < 7) begin
            bn++;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy: got %b expected 0", busy); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rmc_ovf: got %b expected 0", ovf); end
        n_chk++; if (sel !== 2'd0) begin n_fail++; $display("FAIL rmc_sel: got %0d expected 0", sel); end
        n_chk++; if (digit !== 4'b1111) begin n_fail++; $display("FAIL rmc_digit: got %b expected 1111", digit); end
        n_chk++; if (font !== 8'hFF) begin n_fail++; $display("FAIL rmc_font: got %h expected ff", font); end
        @(negedge clk);
        rst = 1'b0;
        model_val = 0; model_ovf = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            es = (edges / 4) % 4;
            n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_post_busy c%0d: got %b expected 0", c, busy); end
            n_chk++; if (sel !== es[1:0]) begin n_fail++; $display("FAIL rmc_post_sel c%0d: got %0d expected %0d", c, sel, es); end
            n_chk++; if (font !== exp_font(0, es, 1'b1)) begin n_fail++; $display("FAIL rmc_post_font c%0d: got %h expected %h", c, font, exp_font(0, es, 1'b1)); end
        end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rmc_post_ovf: got %b expected 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_basic();
        test_overflow();
        test_ignore_load();
        test_enable();
        test_random();
        test_back_to_back();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
